gpr_sb: RTL and testbench
=========================

GPR_SB -- requirements
Module: gpr_sb

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; register count is 2**ADDR_W.
REQ-003 Parameter NRD, default 2: number of independent read ports.
REQ-004 Clk  input  1: clock; all state updates on its rising edge.
REQ-005 Reset  input  1: synchronous, active-high reset.
REQ-006 RAddr  input  NRD*ADDR_W: read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-007 RData  output  NRD*DATA_W: read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-008 RBusy  output  NRD: port k's addressed register has a pending (issued, unwritten) write.
REQ-009 RegWrite  input  1: write enable.
REQ-010 WAddr  input  ADDR_W: write address.
REQ-011 WData  input  DATA_W: write data.
REQ-012 Issue  input  1: marks register IssueAddr as pending a future write.
REQ-013 IssueAddr  input  ADDR_W: register to mark busy.
REQ-014 BusyCnt  output  ADDR_W+1: number of registers currently busy.

Function
REQ-015 The block SHALL hold 2**ADDR_W registers of DATA_W bits and one busy bit per register.
REQ-016 Reads SHALL be combinational: RData port k = register[RAddr k], no clock latency; all NRD ports independent, any port may address any register, including the same one.
REQ-017 Register 0 SHALL always read 0 and never be busy; writes and issues to address 0 are ignored.
REQ-018 On a rising edge with RegWrite=1 and WAddr!=0, register[WAddr] SHALL take WData and busy[WAddr] SHALL clear.
REQ-019 On a rising edge with Issue=1 and IssueAddr!=0, busy[IssueAddr] SHALL set; issuing an already-busy register leaves it busy.
REQ-020 Simultaneous RegWrite and Issue to the same nonzero address: data SHALL be written and busy SHALL end set (issue wins).
REQ-021 Writing a non-busy register is legal; it updates data and leaves busy clear.
REQ-022 BusyCnt SHALL equal the population count of the busy bits as registered after each edge, range 0 to 2**ADDR_W-1; it SHALL never wrap.
REQ-023 RBusy port k SHALL equal busy[RAddr k] (subject to REQ-028), combinationally.

Reset
REQ-024 On a rising edge with Reset=1, all registers SHALL become 0, all busy bits 0 and BusyCnt 0; RegWrite and Issue in that cycle are ignored.
REQ-025 Reset asserted while registers are busy SHALL discard all pending marks; following reads return 0 with RBusy=0.
REQ-026 After reset deasserts, the first edge with RegWrite or Issue SHALL take effect normally.

Configuration
REQ-027 Macro GPR_SB_BYPASS_EN SHALL select write-to-read forwarding.
REQ-028 With GPR_SB_BYPASS_EN defined: when RegWrite=1, WAddr!=0, Reset=0 and RAddr k==WAddr, RData port k SHALL present WData and RBusy port k SHALL be 0 unless Issue=1 with IssueAddr==WAddr in the same cycle.
REQ-029 Without GPR_SB_BYPASS_EN: RData and RBusy SHALL reflect stored state only; a written value is visible from the cycle after the write edge.

Verification
REQ-030 Reset, then read all 32 addresses on both ports -> RData=0, RBusy=0, BusyCnt=0.
REQ-031 Write 0xDEADBEEF to r12, next cycle read r12 on port 0 and port 1 simultaneously -> both return 0xDEADBEEF.
REQ-032 Write 0x12345678 to r0 and Issue r0 -> r0 reads 0, RBusy=0, BusyCnt=0.
REQ-033 Issue r5, Issue r7 -> BusyCnt=2, RBusy=1 for r5; write 0xA5 to r5 -> BusyCnt=1, r5 reads 0xA5 with RBusy=0; same-edge write and Issue on r7 -> r7 stays busy, BusyCnt=1.
REQ-034 Write 0x55 to r3 while reading r3: with GPR_SB_BYPASS_EN, RData=0x55 in the write cycle; without it, old value in that cycle and 0x55 in the next.
REQ-035 Issue r1..r31 over 31 cycles -> BusyCnt=31; assert Reset -> next cycle BusyCnt=0, all registers read 0.

Source files
------------

// File: rtl/gpr_sb.sv
`default_nettype none
// ============================================================================
// Module   : gpr_sb
// Purpose  : Multi-read-port general-purpose register file with a per-register
//            busy scoreboard. Optional write-to-read forwarding is enabled by
//            defining GPR_SB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NRD*ADDR_W-1:0] RAddr,
    output logic [NRD*DATA_W-1:0] RData,
    output logic [NRD-1:0]        RBusy,
    input  logic                  RegWrite,
    input  logic [ADDR_W-1:0]     WAddr,
    input  logic [DATA_W-1:0]     WData,
    input  logic                  Issue,
    input  logic [ADDR_W-1:0]     IssueAddr,
    output logic [ADDR_W:0]       BusyCnt
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    logic w_we;
    logic w_issue;

    // Address 0 is hardwired: it is never written and never marked busy.
    assign w_we    = RegWrite && (WAddr != '0);
    assign w_issue = Issue && (IssueAddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (w_we) begin
            regs_d[WAddr] = WData;
        end
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = '0;
            end
        end
    end

    // The issue mark is applied after the write clear so it wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (w_we) begin
            busy_d[WAddr] = 1'b0;
        end
        if (w_issue) begin
            busy_d[IssueAddr] = 1'b1;
        end
        if (Reset) begin
            busy_d = '0;
        end
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge Clk) begin
        regs_q     <= regs_d;
        busy_q     <= busy_d;
        busy_cnt_q <= busy_cnt_d;
    end

    assign BusyCnt = busy_cnt_q;

`ifdef GPR_SB_BYPASS_EN
    logic w_fwd_en;
    logic w_fwd_busy;
    assign w_fwd_en   = w_we && !Reset;
    assign w_fwd_busy = w_issue && (IssueAddr == WAddr);
`endif

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_stored_data;
        logic              w_stored_busy;

        assign w_ra          = RAddr[k*ADDR_W +: ADDR_W];
        assign w_stored_data = (w_ra == '0) ? '0 : regs_q[w_ra];
        assign w_stored_busy = busy_q[w_ra];

`ifdef GPR_SB_BYPASS_EN
        logic w_hit;
        assign w_hit                   = w_fwd_en && (w_ra == WAddr);
        assign RData[k*DATA_W +: DATA_W] = w_hit ? WData : w_stored_data;
        assign RBusy[k]                = w_hit ? w_fwd_busy : w_stored_busy;
`else
        assign RData[k*DATA_W +: DATA_W] = w_stored_data;
        assign RBusy[k]                = w_stored_busy;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_gpr_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_sb
// Purpose  : Self-checking bench for gpr_sb using directed and random stimulus
//            against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic            clk;
    logic            rst;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]   rbusy;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic            iss;
    logic [AW-1:0]   iaddr;
    logic [AW:0]     busycnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_regs [32];
    logic          m_busy [32];

    gpr_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .RAddr     (raddr),
        .RData     (rdata),
        .RBusy     (rbusy),
        .RegWrite  (we),
        .WAddr     (waddr),
        .WData     (wdata),
        .Issue     (iss),
        .IssueAddr (iaddr),
        .BusyCnt   (busycnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: applies the architectural rules for one clock edge.
    function automatic void model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && waddr != 0) begin
                m_regs[waddr] = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (iss && iaddr != 0) m_busy[iaddr] = 1'b1;
        end
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
`ifdef GPR_SB_BYPASS_EN
        if (we && waddr != 0 && !rst && a == waddr) return wdata;
`endif
        return (a == 0) ? '0 : m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef GPR_SB_BYPASS_EN
        if (we && waddr != 0 && !rst && a == waddr) return iss && (iaddr == waddr);
`endif
        return (a == 0) ? 1'b0 : m_busy[a];
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; waddr = '0; wdata = '0; iss = 0; iaddr = '0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        cycle();
        rst = 0;
        for (int a = 0; a < 32; a++) begin
            raddr = {AW'(31 - a), AW'(a)};
            #1;
            n_tests++;
            if (rdata !== '0 || rbusy !== '0 || busycnt !== '0) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d: rdata=%h rbusy=%b busycnt=%0d, required 0/0/0",
                         a, rdata, rbusy, busycnt);
            end
        end
    endtask

    task automatic test_dual_read();
        we = 1; waddr = 5'd12; wdata = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        raddr = {5'd12, 5'd12};
        #1;
        n_tests++;
        if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL dual_read r12: got %h, required %h", rdata, {32'hDEADBEEF, 32'hDEADBEEF});
        end
    endtask

    task automatic test_zero_reg();
        we = 1; waddr = 0; wdata = 32'h12345678; iss = 1; iaddr = 0;
        cycle();
        idle_inputs();
        raddr = {5'd0, 5'd0};
        #1;
        n_tests++;
        if (rdata !== '0 || rbusy !== 2'b00 || busycnt !== 6'd0) begin
            n_fail++;
            $display("FAIL zero_reg: rdata=%h rbusy=%b busycnt=%0d, required 0/00/0",
                     rdata, rbusy, busycnt);
        end
    endtask

    task automatic test_busy();
        iss = 1; iaddr = 5'd5; cycle();
        iaddr = 5'd7; cycle();
        idle_inputs();
        raddr = {5'd7, 5'd5};
        #1;
        n_tests++;
        if (busycnt !== 6'd2 || rbusy !== 2'b11) begin
            n_fail++;
            $display("FAIL busy_issue: busycnt=%0d rbusy=%b, required 2/11", busycnt, rbusy);
        end
        we = 1; waddr = 5'd5; wdata = 32'hA5; cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (busycnt !== 6'd1 || rbusy !== 2'b10 || rdata[31:0] !== 32'hA5) begin
            n_fail++;
            $display("FAIL busy_clear: busycnt=%0d rbusy=%b r5=%h, required 1/10/a5",
                     busycnt, rbusy, rdata[31:0]);
        end
        we = 1; waddr = 5'd7; wdata = 32'h77; iss = 1; iaddr = 5'd7; cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (busycnt !== 6'd1 || rbusy[1] !== 1'b1 || rdata[63:32] !== 32'h77) begin
            n_fail++;
            $display("FAIL issue_wins: busycnt=%0d rbusy7=%b r7=%h, required 1/1/77",
                     busycnt, rbusy[1], rdata[63:32]);
        end
    endtask

    task automatic test_write_visibility();
        logic [DW-1:0] old_val;
        old_val = m_regs[3];
        raddr = {5'd0, 5'd3};
        we = 1; waddr = 5'd3; wdata = 32'h55;
        #1;
        n_tests++;
`ifdef GPR_SB_BYPASS_EN
        if (rdata[31:0] !== 32'h55 || rbusy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h busy=%b, required 55/0", rdata[31:0], rbusy[0]);
        end
`else
        if (rdata[31:0] !== old_val) begin
            n_fail++;
            $display("FAIL no_bypass_same_cycle: got %h, required %h", rdata[31:0], old_val);
        end
`endif
        cycle();
        idle_inputs();
        #1;
        n_tests++;
        if (rdata[31:0] !== 32'h55) begin
            n_fail++;
            $display("FAIL write_next_cycle: got %h, required 55", rdata[31:0]);
        end
    endtask

    task automatic test_fill_reset();
        for (int i = 1; i < 32; i++) begin
            iss = 1; iaddr = AW'(i);
            cycle();
        end
        idle_inputs();
        #1;
        n_tests++;
        if (busycnt !== 6'd31) begin
            n_fail++;
            $display("FAIL fill_count: busycnt=%0d, required 31", busycnt);
        end
        rst = 1; we = 1; waddr = 5'd9; wdata = 32'hFFFF_0000; iss = 1; iaddr = 5'd4;
        cycle();
        rst = 0; idle_inputs();
        #1;
        n_tests++;
        if (busycnt !== 6'd0) begin
            n_fail++;
            $display("FAIL fill_reset_count: busycnt=%0d, required 0", busycnt);
        end
        for (int a = 0; a < 32; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            n_tests++;
            if (rdata !== '0 || rbusy !== 2'b00) begin
                n_fail++;
                $display("FAIL fill_reset_read addr=%0d: rdata=%h rbusy=%b, required 0/00",
                         a, rdata, rbusy);
            end
        end
        // First edge after reset must take effect normally.
        we = 1; waddr = 5'd9; wdata = 32'hCAFE_F00D; iss = 1; iaddr = 5'd4;
        cycle();
        idle_inputs();
        raddr = {5'd4, 5'd9};
        #1;
        n_tests++;
        if (rdata[31:0] !== 32'hCAFE_F00D || rbusy !== 2'b10 || busycnt !== 6'd1) begin
            n_fail++;
            $display("FAIL post_reset_edge: r9=%h rbusy=%b busycnt=%0d, required cafef00d/10/1",
                     rdata[31:0], rbusy, busycnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            we    = $urandom_range(0, 1) == 1;
            waddr = AW'($urandom_range(0, 31));
            wdata = $urandom;
            iss   = $urandom_range(0, 2) != 0;
            iaddr = ($urandom_range(0, 7) == 0) ? waddr : AW'($urandom_range(0, 31));
            raddr[AW-1:0]  = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
            raddr[2*AW-1:AW] = ($urandom_range(0, 3) == 0) ? raddr[AW-1:0] : AW'($urandom_range(0, 31));
            #1;
            for (int k = 0; k < NR; k++) begin
                logic [AW-1:0] a;
                a = raddr[k*AW +: AW];
                n_tests++;
                if (rdata[k*DW +: DW] !== exp_data(a) || rbusy[k] !== exp_busy(a)) begin
                    n_fail++;
                    $display("FAIL rand_read it=%0d port=%0d addr=%0d: data=%h busy=%b, required %h/%b",
                             n, k, a, rdata[k*DW +: DW], rbusy[k], exp_data(a), exp_busy(a));
                end
            end
            cycle();
            n_tests++;
            if (int'(busycnt) != model_cnt()) begin
                n_fail++;
                $display("FAIL rand_busycnt it=%0d: got %0d, required %0d", n, busycnt, model_cnt());
            end
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        rst = 1; raddr = '0; idle_inputs();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        cycle();
        test_reset();
        test_dual_read();
        test_zero_reg();
        test_busy();
        test_write_visibility();
        test_fill_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
